// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register between MEM and WB: valid/ready handshake with an
// optional two-entry skid buffer, flush, RegWrite masking for rd==0, and a stall counter.
module pipe_reg_elastic #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2,
  parameter int ADDR_W = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [ADDR_W-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_mem,
  output logic [DATA_W-1:0] out_alu,
  output logic [ADDR_W-1:0] out_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              load_head, load_skid, skid_to_head;
  logic              accept, consume;

  logic [CTRL_W-1:0] head_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] head_mem_q, skid_mem_q;
  logic [DATA_W-1:0] head_alu_q, skid_alu_q;
  logic [ADDR_W-1:0] head_rd_q, skid_rd_q;

  // Writes to the zero register are architecturally dead, so drop RegWrite at capture.
  function automatic logic [CTRL_W-1:0] mask_ctrl(input logic [CTRL_W-1:0] ctrl,
                                                  input logic [ADDR_W-1:0] rd);
    logic [CTRL_W-1:0] r;
    r = ctrl;
    if (rd == '0) r[0] = 1'b0;
    return r;
  endfunction

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    load_head    = 1'b0;
    load_skid    = 1'b0;
    skid_to_head = 1'b0;
    stall_d      = stall_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d   = ONE;
          load_head = 1'b1;
        end
        ONE: if (accept && consume) begin
          load_head = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (consume) begin
          state_d = EMPTY;
        end
        FULL: if (consume) begin
          state_d      = ONE;
          skid_to_head = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
    // Registered ready keeps out_ready off the in_ready timing path in skid mode.
    in_ready_d = (state_d != FULL);
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(negedge CLK) begin
    if (!RST_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  always_ff @(negedge CLK) begin
    if (!RST_n) begin
      head_ctrl_q <= '0;
      head_mem_q  <= '0;
      head_alu_q  <= '0;
      head_rd_q   <= '0;
    end else if (load_head) begin
      head_ctrl_q <= mask_ctrl(in_ctrl, in_rd);
      head_mem_q  <= in_mem;
      head_alu_q  <= in_alu;
      head_rd_q   <= in_rd;
    end else if (skid_to_head) begin
      head_ctrl_q <= skid_ctrl_q;
      head_mem_q  <= skid_mem_q;
      head_alu_q  <= skid_alu_q;
      head_rd_q   <= skid_rd_q;
    end
  end

  // Skid slot only loads when it actually receives an entry.
  always_ff @(negedge CLK) begin
    if (RST_n && load_skid) begin
      skid_ctrl_q <= mask_ctrl(in_ctrl, in_rd);
      skid_mem_q  <= in_mem;
      skid_alu_q  <= in_alu;
      skid_rd_q   <= in_rd;
    end
  end

  assign out_ctrl  = out_valid ? head_ctrl_q : '0;
  assign out_mem   = head_mem_q;
  assign out_alu   = head_alu_q;
  assign out_rd    = head_rd_q;
  assign stall_cnt = stall_q;

endmodule
